// File: rtl/mmio_led_ctrl.sv
// mmio_led_ctrl
// Memory-mapped LED peripheral sitting on the CPU data bus. It holds a pattern
// register and drives the LEDs in static, blink or rotate mode. A prescaled
// period timer paces blink and rotate. A free-running 32-bit cycle counter
// is readable by software.
//
// Register window (16 bytes at BASE_ADDR):
//   0x0 DATA   [7:0]  R/W   LED pattern
//   0x4 MODE   [1:0]  R/W   0/3 static, 1 blink, 2 rotate
//   0x8 PERIOD [15:0] R/W   step period in prescaler ticks (0 acts as 1)
//   0xC CYCLE  [31:0] RO    free-running clock counter
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   bus_addr/wdata        byte address and write data
//   bus_we/bus_re         one-cycle write/read strobes
//   bus_rdata/bus_ready   read data, valid during the one-cycle ready pulse
//   led                   registered LED drive
module mmio_led_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter int          CLK_DIV   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_we,
    input  logic        bus_re,
    output logic [31:0] bus_rdata,
    output logic        bus_ready,
    output logic [7:0]  led
);

    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

    // The display state is the MODE register itself; encoding 3 aliases static.
    typedef enum logic [1:0] {
        MODE_STATIC     = 2'd0,
        MODE_BLINK      = 2'd1,
        MODE_ROTATE     = 2'd2,
        MODE_STATIC_ALT = 2'd3
    } mode_e;

    mode_e             state_q;
    logic [7:0]        data_q;
    logic [15:0]       period_q;
    logic [31:0]       cycle_q;
    logic [PRE_W-1:0]  pre_cnt;
    logic [15:0]       per_cnt;
    logic              phase_q;
    logic [7:0]        shreg_q;

    logic              phase_d;
    logic [7:0]        shreg_d;
    logic [7:0]        led_d;

    logic              hit;
    logic [1:0]        reg_sel;
    logic              wr_en;
    logic              rd_en;
    logic              wr_data;
    logic              wr_mode;
    logic              wr_period;
    logic              tick;
    logic              step;
    logic [15:0]       eff_period;
    logic [16:0]       per_sum;
    logic [31:0]       rd_val;
    logic              unused_bits;

    assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:16]};

    // Address decode; a write wins over a simultaneous read.
    assign hit       = (bus_addr[31:4] == BASE_ADDR[31:4]);
    assign reg_sel   = bus_addr[3:2];
    assign wr_en     = bus_we & hit;
    assign rd_en     = bus_re & ~bus_we & hit;
    assign wr_data   = wr_en && (reg_sel == 2'd0);
    assign wr_mode   = wr_en && (reg_sel == 2'd1);
    assign wr_period = wr_en && (reg_sel == 2'd2);

    // The period compare is done one bit wider so per_cnt+1 cannot overflow.
    assign tick       = (pre_cnt == PRE_MAX);
    assign eff_period = (period_q == 16'd0) ? 16'd1 : period_q;
    assign per_sum    = {1'b0, per_cnt} + 17'd1;
    assign step       = tick && (per_sum >= {1'b0, eff_period});

    // Read mux returns the pre-update register values.
    always_comb begin
        rd_val = 32'd0;
        case (reg_sel)
            2'd0: rd_val = {24'd0, data_q};
            2'd1: rd_val = {30'd0, state_q};
            2'd2: rd_val = {16'd0, period_q};
            2'd3: rd_val = cycle_q;
            default: rd_val = 32'd0;
        endcase
    end

    // Software-visible registers and the free-running cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q   <= 8'd0;
            state_q  <= MODE_STATIC;
            period_q <= 16'd4;
            cycle_q  <= 32'd0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (wr_data)
                data_q <= bus_wdata[7:0];
            if (wr_mode)
                state_q <= mode_e'(bus_wdata[1:0]);
            if (wr_period)
                period_q <= bus_wdata[15:0];
        end
    end

    // Prescaler and period counter; a MODE write restarts both timers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            per_cnt <= 16'd0;
        end else if (wr_mode) begin
            pre_cnt <= '0;
            per_cnt <= 16'd0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick)
                per_cnt <= step ? 16'd0 : per_cnt + 16'd1;
        end
    end

    // Every strobe gets exactly one ready pulse; data only for a hit read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_ready <= 1'b0;
            bus_rdata <= 32'd0;
        end else begin
            bus_ready <= bus_we | bus_re;
            bus_rdata <= rd_en ? rd_val : 32'd0;
        end
    end

    // Display next-state logic. A DATA write in rotate mode reloads the
    // shift register and swallows any step landing in the same cycle.
    always_comb begin
        phase_d = phase_q;
        shreg_d = shreg_q;
        led_d   = data_q;
        if (wr_mode) begin
            phase_d = 1'b1;
            shreg_d = data_q;
        end else begin
            case (state_q)
                MODE_BLINK: begin
                    if (step)
                        phase_d = ~phase_q;
                end
                MODE_ROTATE: begin
                    if (wr_data)
                        shreg_d = bus_wdata[7:0];
                    else if (step)
                        shreg_d = {shreg_q[6:0], shreg_q[7]};
                end
                default: begin
                    phase_d = phase_q;
                end
            endcase
        end
        case (state_q)
            MODE_BLINK:  led_d = phase_q ? data_q : 8'h00;
            MODE_ROTATE: led_d = shreg_q;
            default:     led_d = data_q;
        endcase
    end

    // Display state register; led lags the cause of a change by one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= 1'b1;
            shreg_q <= 8'd0;
            led     <= 8'd0;
        end else begin
            phase_q <= phase_d;
            shreg_q <= shreg_d;
            led     <= led_d;
        end
    end

endmodule

// File: doc/mmio_led_ctrl.md
# mmio_led_ctrl

Memory-mapped LED output peripheral on the pipelined MIPS CPU's data bus, directly downstream of the memory stage; it drives the top-level `led[7:0]` pins watched by the system bench. It holds a pattern register and supports static, blink and rotate display modes, with a prescaled period timer. It also provides a free-running 32-bit cycle counter that software can read for timing.

## Interface
- `BASE_ADDR`, default 32'hFFFF_0000: word-aligned base address of the 16-byte register window.
- `CLK_DIV`, default 16: prescaler; one tick every CLK_DIV clocks (legal range ≥1).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `bus_addr`  in  32  byte address; bits [1:0] ignored.
- `bus_wdata`  in  32  write data.
- `bus_we`  in  1  write strobe, one-cycle pulse.
- `bus_re`  in  1  read strobe, one-cycle pulse.
- `bus_rdata`  out  32  read data, valid while `bus_ready`=1.
- `bus_ready`  out  1  one-cycle completion pulse.
- `led`  out  8  LED drive.

## Operation
- Register map, offsets from BASE_ADDR:
  - 0x0 DATA [7:0], R/W.
  - 0x4 MODE [1:0], R/W. 0 = static, 1 = blink, 2 = rotate, 3 = static.
  - 0x8 PERIOD [15:0], R/W, in ticks. A value of 0 is treated as 1.
  - 0xC CYCLE [31:0], read-only free-running counter. Writes are ignored.
- Address decode:
  - Hit when `bus_addr[31:4]` == `BASE_ADDR[31:4]`.
  - On a miss: writes are dropped and reads return 0. `bus_ready` still pulses for every strobe.
  - Unused upper bits read as 0.
- Prescaler:
  - `pre_cnt` counts 0..CLK_DIV-1 and wraps.
  - `tick` is high for the one cycle in which `pre_cnt`==CLK_DIV-1.
- Period counter:
  - `per_cnt` increments on each tick.
  - When `per_cnt`+1 ≥ effective PERIOD, it clears to 0 and raises `step` for that cycle.
- Display state machine, with state = MODE:
  - STATIC: `led` = DATA.
  - BLINK: `phase` toggles on each `step`. `led` = `phase` ? DATA : 8'h00. `phase` resets to 1, so the first period shows DATA.
  - ROTATE: `shreg` rotates left by 1 on each `step` (bit7 → bit0). `led` = `shreg`.
- Writing MODE:
  - Clears `pre_cnt`, `per_cnt`, sets `phase`=1 and loads `shreg`←DATA, all in the same edge.
  - This applies even if the MODE value is unchanged.
- Writing DATA in ROTATE mode reloads `shreg` from the new value. A simultaneous `step` in that cycle is lost.
- Writing PERIOD takes effect immediately. If `per_cnt` is already ≥ the new value, the next tick produces a `step`.
- CYCLE increments every clock and wraps from 0xFFFFFFFF to 0.
- Simultaneous `bus_we` and `bus_re`: the write is performed and the read is ignored. Exactly one `bus_ready` pulse is issued and `bus_rdata` is 0.

## Timing
- Reset values:
  - `led`=0, `bus_ready`=0, `bus_rdata`=0.
  - DATA=0, MODE=0, PERIOD=4, CYCLE=0.
  - `pre_cnt`=0, `per_cnt`=0, `phase`=1, `shreg`=0.
- Reset asserted mid-operation returns all state to these values immediately, without waiting for a clock edge. A pending `bus_ready` is cancelled.
- Bus latency:
  - A strobe sampled at edge N produces `bus_ready`=1 and `bus_rdata` valid in the cycle following edge N. Both return to 0 at edge N+1.
  - Register writes are visible at edge N.
- A read returns the register value at edge N. For CYCLE that is the pre-increment count at edge N.
- Back-to-back strobes on consecutive cycles are legal and give back-to-back `ready` pulses.
- `led` is registered. It changes one edge after the DATA write, `step`, or mode load that caused the change.
- Step interval: CLK_DIV × max(PERIOD,1) clocks.

## Test plan
- Reset: hold `rst` high 12 cycles, then release → `led`=0; read 0x8 → 0x4 with `bus_ready` exactly one cycle after `bus_re`; read 0xC twice, 5 cycles apart → difference 5.
- Static: write DATA=0xA5 → `led`=0xA5 from the next edge and stable for 200 cycles; read 0x0 → 0x000000A5.
- Blink (CLK_DIV=16): DATA=0x0F, PERIOD=2, MODE=1 → `led` alternates 0x0F / 0x00 every 32 clocks, starting with 0x0F.
- Rotate: DATA=0x81, PERIOD=1, MODE=2 → `led` sequence 0x81, 0x03, 0x06, 0x0C… changing every 16 clocks; write DATA=0x01 mid-run → next `led`=0x01.
- Decode and collision: write to BASE+0x10 → no state change, ready pulses; read BASE+0x10 → 0; simultaneous `we`/`re` to DATA=0x3C → single ready, `rdata`=0, DATA=0x3C.
- Async reset mid-rotate: assert `rst` between edges → `led`=0 without a clock edge; after release MODE reads 0 and PERIOD reads 4.
